// File: rtl/hazard_unit.sv
// Hazard and pipeline-control unit for the 5-stage RV32I pipeline (F/D/E/M/W).
// Latency: forwarding/stall/flush are combinational; the memory-wait state and the stall counter are registered.
// Backpressure: stalls F/D while a RAW hazard is unresolved, and stalls F/D/E/M while a slow load occupies M.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   Rs1D_i/Rs2D_i, Rs1E_i/Rs2E_i  source register indices in D and E
//   RdE_i/RdM_i/RdW_i             destination indices in E/M/W, qualified by RegWrite*_i
//   LoadE_i, LoadM_i              load instruction present in E / M
//   PCSrcE_i                      taken branch/jump resolved in E
//   ForwardAE_o/ForwardBE_o       00 regfile, 10 ALUResultM, 01 Result (W)
//   Stall*_o, Flush*_o            enable/clear controls for the pipeline registers
//   StallCycles_o                 saturating count of cycles with StallF_o=1
module hazard_unit #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int FWD_EN        = 1,
    parameter int MEM_LATENCY   = 0,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] Rs1D_i,
    input  logic [ADDRESS_WIDTH-1:0] Rs2D_i,
    input  logic [ADDRESS_WIDTH-1:0] Rs1E_i,
    input  logic [ADDRESS_WIDTH-1:0] Rs2E_i,
    input  logic [ADDRESS_WIDTH-1:0] RdE_i,
    input  logic [ADDRESS_WIDTH-1:0] RdM_i,
    input  logic [ADDRESS_WIDTH-1:0] RdW_i,
    input  logic                     RegWriteE_i,
    input  logic                     RegWriteM_i,
    input  logic                     RegWriteW_i,
    input  logic                     LoadE_i,
    input  logic                     LoadM_i,
    input  logic                     PCSrcE_i,
    output logic [1:0]               ForwardAE_o,
    output logic [1:0]               ForwardBE_o,
    output logic                     StallF_o,
    output logic                     StallD_o,
    output logic                     StallE_o,
    output logic                     StallM_o,
    output logic                     FlushD_o,
    output logic                     FlushE_o,
    output logic                     FlushW_o,
    output logic [CNT_WIDTH-1:0]     StallCycles_o
);

    logic ms;   // memory wait in progress
    logic ds;   // data (RAW) hazard on a D-stage source

    // Some inputs are only consumed in certain parameterisations.
    logic unused_inputs;
    assign unused_inputs = LoadM_i ^ LoadE_i;

    // x0 is hard-wired to zero, so it never produces a dependency.
    function automatic logic hit(input logic                     we,
                                 input logic [ADDRESS_WIDTH-1:0] rd,
                                 input logic [ADDRESS_WIDTH-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [ADDRESS_WIDTH-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (FWD_EN != 0) begin
            if (hit(RegWriteM_i, RdM_i, rs))      sel = 2'b10;   // youngest producer wins
            else if (hit(RegWriteW_i, RdW_i, rs)) sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ds = 1'b0;
        if (FWD_EN != 0) begin
            // Only a load in E cannot be covered by forwarding.
            ds = LoadE_i && (hit(1'b1, RdE_i, Rs1D_i) || hit(1'b1, RdE_i, Rs2D_i));
        end else begin
            // Without bypass every in-flight writer blocks; W is included because
            // the register file does not write before read.
            ds = hit(RegWriteE_i, RdE_i, Rs1D_i) || hit(RegWriteE_i, RdE_i, Rs2D_i) ||
                 hit(RegWriteM_i, RdM_i, Rs1D_i) || hit(RegWriteM_i, RdM_i, Rs2D_i) ||
                 hit(RegWriteW_i, RdW_i, Rs1D_i) || hit(RegWriteW_i, RdW_i, Rs2D_i);
        end
    end

    generate
        if (MEM_LATENCY > 0) begin : g_mem_wait
            typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;
            state_t     state_q, state_d;
            logic [3:0] cnt_q, cnt_d;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // WAIT lasts cnt+1 cycles, so loading LATENCY-1 gives exactly LATENCY
            // stalled cycles. RELEASE lets the load move on to W before a new
            // load in M can be accepted.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                ms      = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (LoadM_i) begin
                            cnt_d   = 4'(MEM_LATENCY - 1);
                            state_d = WAIT;
                        end
                    end
                    WAIT: begin
                        ms = 1'b1;
                        if (cnt_q == 4'd0) state_d = RELEASE;
                        else               cnt_d   = cnt_q - 4'd1;
                    end
                    RELEASE: state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end else begin : g_no_mem_wait
            assign ms = 1'b0;
        end
    endgenerate

    always_comb begin
        ForwardAE_o = fwd_sel(Rs1E_i);
        ForwardBE_o = fwd_sel(Rs2E_i);
        StallM_o    = ms;
        StallE_o    = ms;
        FlushW_o    = ms;
        // A redirect in E supersedes a load-use stall: the dependent instruction is squashed anyway.
        StallF_o    = ms || (ds && !PCSrcE_i);
        StallD_o    = ms || (ds && !PCSrcE_i);
        // Flushes wait until M releases; a branch held in E is acted on afterwards.
        FlushE_o    = !ms && (PCSrcE_i || ds);
        FlushD_o    = !ms && PCSrcE_i;
        if (rst_i) begin
            ForwardAE_o = 2'b00;
            ForwardBE_o = 2'b00;
            StallF_o    = 1'b0;
            StallD_o    = 1'b0;
            StallE_o    = 1'b0;
            StallM_o    = 1'b0;
            FlushD_o    = 1'b1;
            FlushE_o    = 1'b1;
            FlushW_o    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            StallCycles_o <= '0;
        end else if (StallF_o && (StallCycles_o != '1)) begin
            StallCycles_o <= StallCycles_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances (forwarding + 3-cycle memory, stall-only,
// forwarding + 2-cycle memory with a 3-bit counter) share one set of inputs.
// A timeline model of the memory wait and counter is checked every cycle.
module tb_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww, loade, loadm, pcsrc;

    logic [1:0] fae [3];
    logic [1:0] fbe [3];
    logic       stf [3], sdd [3], ste [3], stm [3], fld [3], fle [3], flw [3];
    logic [31:0] sc0, sc1;
    logic [2:0]  sc2;

    hazard_unit #(.ADDRESS_WIDTH(5), .FWD_EN(1), .MEM_LATENCY(3), .CNT_WIDTH(32)) u_a (
        .clk_i(clk), .rst_i(rst), .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw), .RegWriteE_i(rwe), .RegWriteM_i(rwm),
        .RegWriteW_i(rww), .LoadE_i(loade), .LoadM_i(loadm), .PCSrcE_i(pcsrc),
        .ForwardAE_o(fae[0]), .ForwardBE_o(fbe[0]), .StallF_o(stf[0]), .StallD_o(sdd[0]),
        .StallE_o(ste[0]), .StallM_o(stm[0]), .FlushD_o(fld[0]), .FlushE_o(fle[0]),
        .FlushW_o(flw[0]), .StallCycles_o(sc0));

    hazard_unit #(.ADDRESS_WIDTH(5), .FWD_EN(0), .MEM_LATENCY(0), .CNT_WIDTH(32)) u_b (
        .clk_i(clk), .rst_i(rst), .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw), .RegWriteE_i(rwe), .RegWriteM_i(rwm),
        .RegWriteW_i(rww), .LoadE_i(loade), .LoadM_i(loadm), .PCSrcE_i(pcsrc),
        .ForwardAE_o(fae[1]), .ForwardBE_o(fbe[1]), .StallF_o(stf[1]), .StallD_o(sdd[1]),
        .StallE_o(ste[1]), .StallM_o(stm[1]), .FlushD_o(fld[1]), .FlushE_o(fle[1]),
        .FlushW_o(flw[1]), .StallCycles_o(sc1));

    hazard_unit #(.ADDRESS_WIDTH(5), .FWD_EN(1), .MEM_LATENCY(2), .CNT_WIDTH(3)) u_c (
        .clk_i(clk), .rst_i(rst), .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw), .RegWriteE_i(rwe), .RegWriteM_i(rwm),
        .RegWriteW_i(rww), .LoadE_i(loade), .LoadM_i(loadm), .PCSrcE_i(pcsrc),
        .ForwardAE_o(fae[2]), .ForwardBE_o(fbe[2]), .StallF_o(stf[2]), .StallD_o(sdd[2]),
        .StallE_o(ste[2]), .StallM_o(stm[2]), .FlushD_o(fld[2]), .FlushE_o(fle[2]),
        .FlushW_o(flw[2]), .StallCycles_o(sc2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The memory wait is modelled as a timeline: a load accepted at cycle s stalls
    // cycles s+1..s+L, and the unit is busy (cannot accept) through s+L+1.
    int     lat  [3] = '{3, 0, 2};
    bit     fwdp [3] = '{1'b1, 1'b0, 1'b1};
    longint cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};
    int     lt   [3];
    longint mcnt [3];
    int     t;

    function automatic bit dep(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && rd != 5'd0 && rd == rs;
    endfunction

    function automatic bit ms_of(input int i);
        return lat[i] > 0 && t >= lt[i] + 1 && t <= lt[i] + lat[i];
    endfunction

    function automatic bit ds_of(input int i);
        if (fwdp[i]) return loade && rde != 5'd0 && (rde == rs1d || rde == rs2d);
        return dep(rwe, rde, rs1d) || dep(rwe, rde, rs2d) || dep(rwm, rdm, rs1d) ||
               dep(rwm, rdm, rs2d) || dep(rww, rdw, rs1d) || dep(rww, rdw, rs2d);
    endfunction

    function automatic logic [1:0] fw_of(input int i, input logic [4:0] rs);
        if (!fwdp[i]) return 2'b00;
        if (dep(rwm, rdm, rs)) return 2'b10;
        if (dep(rww, rdw, rs)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] getsc(input int i);
        if (i == 0) return sc0;
        if (i == 1) return sc1;
        return {29'd0, sc2};
    endfunction

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            bit ms, ds, st, fe, fd, fwb;
            logic [1:0] fa, fb;
            ms = ms_of(i);
            ds = ds_of(i);
            fa = fw_of(i, rs1e);
            fb = fw_of(i, rs2e);
            st = ms || (ds && !pcsrc);
            fe = !ms && (pcsrc || ds);
            fd = !ms && pcsrc;
            fwb = ms;
            if (rst) begin
                fa = 2'b00; fb = 2'b00; st = 0; ms = 0; fe = 1; fd = 1; fwb = 1;
            end
            chk($sformatf("m%0d_t%0d_fwdA", i, t), 32'(fae[i]), 32'(fa));
            chk($sformatf("m%0d_t%0d_fwdB", i, t), 32'(fbe[i]), 32'(fb));
            chk($sformatf("m%0d_t%0d_stallF", i, t), 32'(stf[i]), 32'(st));
            chk($sformatf("m%0d_t%0d_stallD", i, t), 32'(sdd[i]), 32'(st));
            chk($sformatf("m%0d_t%0d_stallE", i, t), 32'(ste[i]), 32'(ms));
            chk($sformatf("m%0d_t%0d_stallM", i, t), 32'(stm[i]), 32'(ms));
            chk($sformatf("m%0d_t%0d_flushD", i, t), 32'(fld[i]), 32'(fd));
            chk($sformatf("m%0d_t%0d_flushE", i, t), 32'(fle[i]), 32'(fe));
            chk($sformatf("m%0d_t%0d_flushW", i, t), 32'(flw[i]), 32'(fwb));
            chk($sformatf("m%0d_t%0d_count", i, t), getsc(i), 32'(mcnt[i]));
        end
    endtask

    task automatic model_adv();
        for (int i = 0; i < 3; i++) begin
            bit st;
            st = !rst && (ms_of(i) || (ds_of(i) && !pcsrc));
            if (rst) begin
                lt[i]   = -1000;
                mcnt[i] = 0;
            end else begin
                if (lat[i] > 0 && loadm && !(t >= lt[i] + 1 && t <= lt[i] + lat[i] + 1)) lt[i] = t;
                if (st && mcnt[i] < cmax[i]) mcnt[i]++;
            end
        end
        t++;
    endtask

    // Inputs are driven while clk is low; checks happen 1 time unit later.
    task automatic cyc();
        #1;
        model_check();
        @(posedge clk);
        model_adv();
        @(negedge clk);
    endtask

    task automatic clr_in();
        {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
        {rwe, rwm, rww, loade, loadm, pcsrc} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwe, rwm, rww, loade, pcsrc;
        logic [1:0] fa, fb;
        logic       st_a, fe_a, fd, st_b, fe_b;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 7, 6, 0, 7, 6, 0, 1, 1, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 1, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1, 1, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1, 0, 1};
        vecs[7]  = '{3, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1};
        vecs[8]  = '{4, 0, 4, 0, 0, 4, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 9, 0, 0, 0, 9, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 8, 8, 0, 8, 8, 0, 1, 1, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0};

        for (int i = 0; i < 3; i++) begin lt[i] = -1000; mcnt[i] = 0; end
        t   = 0;
        rst = 1'b1;
        clr_in();
        @(negedge clk);
        @(negedge clk);

        // Reset state.
        #1;
        chk("reset_stallF", 32'(stf[0]), 32'd0);
        chk("reset_flushW", 32'(flw[0]), 32'd1);
        chk("reset_count",  sc0,         32'd0);
        cyc();
        rst = 1'b0;

        foreach (vecs[k]) begin
            rs1d = vecs[k].rs1d; rs2d = vecs[k].rs2d; rs1e = vecs[k].rs1e; rs2e = vecs[k].rs2e;
            rde = vecs[k].rde; rdm = vecs[k].rdm; rdw = vecs[k].rdw;
            rwe = vecs[k].rwe; rwm = vecs[k].rwm; rww = vecs[k].rww;
            loade = vecs[k].loade; pcsrc = vecs[k].pcsrc; loadm = 1'b0;
            #1;
            chk($sformatf("vec%0d_fwdA", k),    32'(fae[0]), 32'(vecs[k].fa));
            chk($sformatf("vec%0d_fwdB", k),    32'(fbe[0]), 32'(vecs[k].fb));
            chk($sformatf("vec%0d_stallA", k),  32'(stf[0]), 32'(vecs[k].st_a));
            chk($sformatf("vec%0d_flushEA", k), 32'(fle[0]), 32'(vecs[k].fe_a));
            chk($sformatf("vec%0d_flushD", k),  32'(fld[0]), 32'(vecs[k].fd));
            chk($sformatf("vec%0d_stallB", k),  32'(stf[1]), 32'(vecs[k].st_b));
            chk($sformatf("vec%0d_flushEB", k), 32'(fle[1]), 32'(vecs[k].fe_b));
            chk($sformatf("vec%0d_fwdA_nofwd", k), 32'(fae[1]), 32'd0);
            cyc();
        end

        // Load-use: one stall cycle, counter advances by one.
        do_reset();
        loade = 1; rwe = 1; rde = 7; rs2d = 7;
        #1;
        chk("lu_stallF", 32'(stf[0]), 32'd1);
        chk("lu_flushE", 32'(fle[0]), 32'd1);
        cyc();
        clr_in();
        #1;
        chk("lu_release", 32'(stf[0]), 32'd0);
        chk("lu_count",   sc0,         32'd1);
        cyc();

        // Stall-only interlock: dependency seen in E, then M, then W.
        clr_in(); rwe = 1; rde = 3; rs1d = 3;
        #1; chk("il_E", 32'(stf[1] & fle[1]), 32'd1); cyc();
        clr_in(); rwm = 1; rdm = 3; rs1d = 3;
        #1; chk("il_M", 32'(stf[1] & fle[1]), 32'd1); cyc();
        clr_in(); rww = 1; rdw = 3; rs1d = 3;
        #1; chk("il_W", 32'(stf[1] & fle[1]), 32'd1); cyc();
        clr_in();
        #1; chk("il_done", 32'(stf[1] | fle[1]), 32'd0); cyc();

        // Memory wait with a back-to-back load.
        do_reset();
        loadm = 1;
        #1; chk("mw_accept", 32'(stf[0]), 32'd0); cyc();
        for (int k = 0; k < 3; k++) begin
            #1; chk($sformatf("mw_wait%0d", k), 32'({stf[0], sdd[0], ste[0], stm[0], flw[0]}), 32'h1f);
            cyc();
        end
        #1; chk("mw_release", 32'({stf[0], stm[0], flw[0]}), 32'd0); cyc();
        #1; chk("mw_idle2", 32'(stf[0]), 32'd0); cyc();
        for (int k = 0; k < 3; k++) begin
            #1; chk($sformatf("mw2_wait%0d", k), 32'({stf[0], stm[0], flw[0]}), 32'h7);
            cyc();
        end
        loadm = 0;
        #1; chk("mw2_release", 32'(stf[0]), 32'd0); cyc();

        // Branch held in E during a 2-cycle wait.
        do_reset();
        loadm = 1; cyc();
        pcsrc = 1;
        for (int k = 0; k < 2; k++) begin
            #1; chk($sformatf("bw_held%0d", k), 32'({fld[2], fle[2]}), 32'd0);
            cyc();
        end
        loadm = 0;
        #1; chk("bw_flush", 32'({fld[2], fle[2], stf[2]}), 32'h6); cyc();
        clr_in(); cyc();

        // Reset in the middle of a wait.
        do_reset();
        loadm = 1; cyc();
        rst = 1; loadm = 0;
        #1; chk("rw_forced", 32'({stf[0], flw[0]}), 32'd1); cyc();
        #1;
        chk("rw_idle", 32'({stf[0], stm[0], fld[0], fle[0], flw[0]}), 32'h7);
        chk("rw_count", sc0, 32'd0);
        cyc();
        rst = 0; loadm = 1;
        #1; chk("rw_accept", 32'(stf[0]), 32'd0); cyc();
        loadm = 0;
        for (int k = 0; k < 3; k++) begin
            #1; chk($sformatf("rw_wait%0d", k), 32'(stf[0]), 32'd1); cyc();
        end
        #1; chk("rw_release", 32'(stf[0]), 32'd0); cyc();

        // Counter saturation on the 3-bit instance.
        do_reset();
        loade = 1; rwe = 1; rde = 7; rs2d = 7;
        repeat (10) cyc();
        clr_in();
        #1;
        chk("sat_count3",  {29'd0, sc2}, 32'd7);
        chk("sat_count32", sc0,          32'd10);
        cyc();

        // Randomised traffic with small register indices to provoke matches.
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            rs1d  = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
            rs1e  = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
            rde   = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
            rdw   = 5'($urandom_range(0, 3));
            rwe   = 1'($urandom); rwm = 1'($urandom); rww = 1'($urandom);
            loade = 1'($urandom);
            loadm = ($urandom_range(0, 3) == 0);
            pcsrc = loade ? 1'b0 : ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage RV32I core (F/D/E/M/W).
- Generates the E-stage forwarding selects, plus stall and flush enables for every pipeline register.
- Supports a configurable multi-cycle data-memory wait.
- Can be built without forwarding, in which case all RAW hazards are resolved by stall-only interlock.
- Instantiated once in top, driving the en/clr inputs of pc_reg and every pipeline register.

Parameters:
ADDRESS_WIDTH, 5, register index width.
FWD_EN, 1, 1 = forwarding enabled; 0 = RAW hazards resolved by stalling only.
MEM_LATENCY, 0, extra wait cycles per load in M (0..15); 0 = single-cycle data memory.
CNT_WIDTH, 32, width of the stall-cycle performance counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
Rs1D_i, Rs2D_i  in  ADDRESS_WIDTH  source registers in D
Rs1E_i, Rs2E_i  in  ADDRESS_WIDTH  source registers in E
RdE_i, RdM_i, RdW_i  in  ADDRESS_WIDTH  destination registers in E/M/W
RegWriteE_i, RegWriteM_i, RegWriteW_i  in  1  register write enables in E/M/W
LoadE_i  in  1  instruction in E is a load (ResultSrcE selects memory)
LoadM_i  in  1  instruction in M is a load
PCSrcE_i  in  1  taken branch/jump resolved in E
ForwardAE_o, ForwardBE_o  out  2  00 = regfile, 10 = ALUResultM, 01 = Result (W)
StallF_o, StallD_o, StallE_o, StallM_o  out  1  hold the pipeline register feeding that stage
FlushD_o, FlushE_o, FlushW_o  out  1  insert a bubble into that stage
StallCycles_o  out  CNT_WIDTH  saturating count of cycles with StallF_o=1

Behaviour:
- Clock and reset: single clock, clk_i. Reset is synchronous and active-high on rst_i.
- While rst_i=1:
  - FSM goes to IDLE, wait counter to 0, StallCycles_o to 0.
  - Outputs are forced: FlushD_o=FlushE_o=FlushW_o=1, all Stall*_o=0, Forward*_o=00.
- A register index of 0 never matches: x0 causes no forwarding and no stall.

Forwarding (combinational; FWD_EN=1 only):
- ForwardAE_o=10 if RegWriteM_i && RdM_i!=0 && RdM_i==Rs1E_i.
- Otherwise ForwardAE_o=01 if RegWriteW_i && RdW_i!=0 && RdW_i==Rs1E_i.
- Otherwise ForwardAE_o=00. M has priority over W.
- ForwardBE_o is identical, using Rs2E_i.
- FWD_EN=0: both outputs are tied to 00.

Data stall, ds (combinational):
- FWD_EN=1: ds = LoadE_i && RdE_i!=0 && (RdE_i==Rs1D_i || RdE_i==Rs2D_i).
- FWD_EN=0: ds = 1 if any of E/M/W has RegWrite=1, Rd!=0 and Rd equal to Rs1D_i or Rs2D_i.
  - The W match is included because the regfile is not write-before-read.

Memory-wait FSM (exists when MEM_LATENCY>0; otherwise ms=0 always):
- IDLE: if LoadM_i, load cnt=MEM_LATENCY-1 and go to WAIT.
- WAIT: ms=1. If cnt==0 go to RELEASE, else cnt decrements.
- RELEASE: ms=0 (the load advances to W); next state is IDLE.
  - Back-to-back loads: the second load reaches M during RELEASE and triggers from IDLE on the following cycle.
- ms is a combinational decode of the registered state.
- Each load therefore holds M for exactly MEM_LATENCY cycles.

Output equations:
- StallM_o = StallE_o = ms.
- FlushW_o = ms.
- StallF_o = StallD_o = ms || (ds && !PCSrcE_i).
- FlushE_o = !ms && (PCSrcE_i || ds).
- FlushD_o = !ms && PCSrcE_i.
- While ms=1, a branch held in E is not acted on. Its flush is issued on the first cycle ms=0 after WAIT.
- LoadE_i and PCSrcE_i are mutually exclusive by ISA. No priority between them is required, but PCSrcE_i overrides ds as written above.

Counter:
- StallCycles_o increments each clock with StallF_o=1 and rst_i=0.
- It saturates at all-ones.

Test Plan:
- Forwarding: FWD_EN=1, add x5 in M (RegWriteM=1, RdM=5), Rs1E=5, and x5 also in W -> ForwardAE_o=10 (M wins). Same case with RdM=0 and Rs1E=0 -> ForwardAE_o=00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 -> exactly 1 cycle with StallF=StallD=FlushE=1, then all deasserted. StallCycles_o increments by 1.
- Stall-only interlock: FWD_EN=0, RegWriteE=1, RdE=3, Rs1D=3, and the dependency retires one stage per cycle -> StallF/StallD high for 3 cycles (match in E, then M, then W). FlushE_o high for the same 3 cycles.
- Memory wait: MEM_LATENCY=3, LoadM=1 -> StallF/D/E/M=1 and FlushW=1 for exactly 3 cycles, then 1 RELEASE cycle with all 0. A second load entering M during RELEASE -> another 3-cycle wait starting 1 cycle later.
- Branch during wait: MEM_LATENCY=2, PCSrcE=1 asserted throughout the WAIT -> FlushD/FlushE stay 0 for 2 cycles, then are 1 in the RELEASE cycle.
- Reset mid-wait: rst_i=1 during WAIT -> next cycle FSM is IDLE, Stall*=0, Flush*=1, StallCycles_o=0. After rst_i=0, LoadM=1 -> a full MEM_LATENCY wait.
